encrypt_pipe_ctrl: RTL and testbench

Issue and key-management controller for the 10-stage pipelined AES-128 encrypt datapath. The datapath is free-running and has no valid, enable or stall signals. This block:
- accepts tagged plaintext blocks over a valid/ready handshake,
- tracks them through the pipeline with a valid/tag shift register,
- buffers ciphertext in a credit-protected output FIFO so downstream backpressure never loses a result,
- drains the pipeline and sequences the external key schedule whenever a new key is loaded.

---
 rtl/enc_pkg.sv | 24 ++
 rtl/enc_out_fifo.sv | 73 +++++++
 rtl/encrypt_pipe_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_encrypt_pipe_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared widths, latency and controller state encoding for the AES-128 encrypt pipeline slice.
package enc_pkg;

    localparam int AES_BLK_W        = 128;
    localparam int AES_KEY_W        = 128;
    localparam int ENC_PIPE_LATENCY = 10;

    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        KEXP  = 2'd3
    } enc_ctrl_state_t;

    function automatic int unsigned enc_popcount(input logic [31:0] bits);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/enc_out_fifo.sv
// Synchronous ciphertext FIFO with registered valid and occupancy count; pointers wrap modulo DEPTH.
module enc_out_fifo
    import enc_pkg::*;
#(
    parameter int WIDTH = AES_BLK_W + 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             valid_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A full FIFO refuses the write rather than overwrite the oldest result.
    assign push_ok_s = push && (count_r != CNT_W'(DEPTH));
    assign pop_ok_s  = pop && valid_r;

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage, pointers and registered valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != '0);
        end
    end

    assign valid = valid_r;
    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/encrypt_pipe_ctrl.sv
// Issue and key-management controller for the free-running AES-128 encrypt pipeline.
// Define ENC_PIPE_STATS_EN to add the stat_blocks / stat_stalls counters.
module encrypt_pipe_ctrl
    import enc_pkg::*;
#(
    parameter int LATENCY   = ENC_PIPE_LATENCY,
    parameter int TAG_W     = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 key_load_valid,
    output logic                 key_load_ready,
    input  logic [AES_KEY_W-1:0] key_load_data,
    output logic [AES_BLK_W-1:0] pt_out,
    output logic [AES_KEY_W-1:0] key_out,
    output logic                 ks_start,
    input  logic                 ks_done,
    input  logic [AES_BLK_W-1:0] ct_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic [TAG_W-1:0]     out_tag
`ifdef ENC_PIPE_STATS_EN
    ,
    output logic [31:0]          stat_blocks,
    output logic [31:0]          stat_stalls
`endif
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int ENT_W = AES_BLK_W + TAG_W;

    enc_ctrl_state_t      state_r;
    logic [LATENCY-1:0]   vld_r;
    logic [TAG_W-1:0]     tag_r [LATENCY];
    logic [AES_KEY_W-1:0] key_pend_r;
    logic [AES_KEY_W-1:0] key_out_r;
    logic                 ks_start_r;
    logic                 in_ready_r;
    logic                 key_load_ready_r;

    logic                 issue_s;
    logic                 key_hs_s;
    logic                 retire_s;
    logic                 pop_s;
    logic                 fifo_valid_s;
    logic [ENT_W-1:0]     fifo_head_s;
    logic [CNT_W-1:0]     fifo_count_s;
    logic [31:0]          credit_next_s;
    logic                 room_next_s;

    assign issue_s  = in_valid && in_ready_r;
    assign key_hs_s = key_load_valid && key_load_ready_r;
    assign retire_s = vld_r[LATENCY-1];
    assign pop_s    = fifo_valid_s && out_ready;

    // Credits held next cycle: blocks in flight plus buffered results, after this cycle's issue and pop.
    always_comb begin
        credit_next_s = enc_popcount(32'(vld_r)) + 32'(fifo_count_s);
        if (issue_s && !pop_s) begin
            credit_next_s = credit_next_s + 32'd1;
        end else if (!issue_s && pop_s) begin
            credit_next_s = credit_next_s - 32'd1;
        end else begin
            credit_next_s = credit_next_s;
        end
    end

    assign room_next_s = (credit_next_s < 32'(OUT_DEPTH));

    // Valid/tag shadow of the datapath: shifts every cycle since the datapath never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            vld_r    <= {vld_r[LATENCY-2:0], issue_s};
            tag_r[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Controller FSM; handshake readies and ks_start are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= NOKEY;
            key_pend_r       <= '0;
            key_out_r        <= '0;
            ks_start_r       <= 1'b0;
            in_ready_r       <= 1'b0;
            key_load_ready_r <= 1'b1;
        end else begin
            ks_start_r <= 1'b0;
            case (state_r)
                NOKEY: begin
                    in_ready_r <= 1'b0;
                    if (key_hs_s) begin
                        key_pend_r       <= key_load_data;
                        key_load_ready_r <= 1'b0;
                        state_r          <= DRAIN;
                    end else begin
                        key_load_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (key_hs_s) begin
                        key_pend_r       <= key_load_data;
                        key_load_ready_r <= 1'b0;
                        in_ready_r       <= 1'b0;
                        state_r          <= DRAIN;
                    end else begin
                        key_load_ready_r <= 1'b1;
                        in_ready_r       <= room_next_s;
                    end
                end
                DRAIN: begin
                    in_ready_r       <= 1'b0;
                    key_load_ready_r <= 1'b0;
                    if (vld_r == '0) begin
                        key_out_r  <= key_pend_r;
                        ks_start_r <= 1'b1;
                        state_r    <= KEXP;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                KEXP: begin
                    if (ks_done) begin
                        in_ready_r       <= room_next_s;
                        key_load_ready_r <= 1'b1;
                        state_r          <= RUN;
                    end else begin
                        in_ready_r       <= 1'b0;
                        key_load_ready_r <= 1'b0;
                    end
                end
                default: begin
                    in_ready_r       <= 1'b0;
                    key_load_ready_r <= 1'b1;
                    state_r          <= NOKEY;
                end
            endcase
        end
    end

    enc_out_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (OUT_DEPTH),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (retire_s),
        .push_data ({ct_in, tag_r[LATENCY-1]}),
        .pop       (pop_s),
        .valid     (fifo_valid_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s)
    );

    assign pt_out         = in_data;
    assign key_out        = key_out_r;
    assign ks_start       = ks_start_r;
    assign in_ready       = in_ready_r;
    assign key_load_ready = key_load_ready_r;
    assign out_valid      = fifo_valid_s;
    assign out_data       = fifo_head_s[ENT_W-1:TAG_W];
    assign out_tag        = fifo_head_s[TAG_W-1:0];

`ifdef ENC_PIPE_STATS_EN
    logic [31:0] stat_blocks_r;
    logic [31:0] stat_stalls_r;

    // Accepted-block and stalled-offer counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_blocks_r <= 32'd0;
            stat_stalls_r <= 32'd0;
        end else begin
            if (issue_s) begin
                stat_blocks_r <= stat_blocks_r + 32'd1;
            end
            if (in_valid && !in_ready_r) begin
                stat_stalls_r <= stat_stalls_r + 32'd1;
            end
        end
    end

    assign stat_blocks = stat_blocks_r;
    assign stat_stalls = stat_stalls_r;
`endif

endmodule

// File: tb/tb_encrypt_pipe_ctrl.sv
// Directed self-checking bench for encrypt_pipe_ctrl with a latency-accurate datapath stand-in.
module tb_encrypt_pipe_ctrl;
    import enc_pkg::*;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] NEW_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   in_tag;
    logic         key_load_valid;
    logic         key_load_ready;
    logic [127:0] key_load_data;
    logic [127:0] pt_out;
    logic [127:0] key_out;
    logic         ks_start;
    logic         ks_done;
    logic [127:0] ct_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_tag;
`ifdef ENC_PIPE_STATS_EN
    logic [31:0]  stat_blocks;
    logic [31:0]  stat_stalls;
`endif

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_out = 0;
    logic accepted;
    logic key_acc;
    logic [127:0] model_key;
    logic [131:0] exp_q [$];
    logic [127:0] dp [ENC_PIPE_LATENCY];

    encrypt_pipe_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_tag         (in_tag),
        .key_load_valid (key_load_valid),
        .key_load_ready (key_load_ready),
        .key_load_data  (key_load_data),
        .pt_out         (pt_out),
        .key_out        (key_out),
        .ks_start       (ks_start),
        .ks_done        (ks_done),
        .ct_in          (ct_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_tag        (out_tag)
`ifdef ENC_PIPE_STATS_EN
        ,
        .stat_blocks    (stat_blocks),
        .stat_stalls    (stat_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cipher stand-in: real AES result for the FIPS-197 vector, XOR otherwise.
    function automatic logic [127:0] dp_model(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        else return pt ^ key;
    endfunction

    // Free-running datapath: samples pt_out/key_out every edge, result appears LATENCY cycles later.
    always @(posedge clk) begin
        dp[0] <= dp_model(pt_out, key_out);
        for (int k = 1; k < ENC_PIPE_LATENCY; k++) dp[k] <= dp[k-1];
    end
    assign ct_in = dp[ENC_PIPE_LATENCY-1];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes at the falling edge, then advance past the rising edge.
    task automatic tick();
        logic [131:0] e;
        @(negedge clk);
        accepted = 1'b0;
        key_acc  = key_load_valid && key_load_ready;
        if (in_valid && in_ready) begin
            exp_q.push_back({dp_model(in_data, model_key), in_tag});
            accepted = 1'b1;
            n_acc++;
        end
        if (out_valid && out_ready) begin
            check("out_has_expected", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", out_data, e[131:4]);
                check("out_tag", 128'(out_tag), 128'(e[3:0]));
            end
            n_out++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [127:0] d, input logic [3:0] t);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        do begin
            tick();
            w++;
        end while (!accepted && w < 100);
        check("issue_accepted", 128'(accepted), 128'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            tick();
            w++;
        end
        check("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        int n;
        int j;
        int n0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 128'd0; in_tag = 4'd0;
        key_load_valid = 1'b0; key_load_data = 128'd0; ks_done = 1'b0; out_ready = 1'b0;
        model_key = 128'd0; accepted = 1'b0; key_acc = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_klr", 128'(key_load_ready), 128'd1);
        check("rst_ks_start", 128'(ks_start), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_key_out", key_out, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_tag", 128'(out_tag), 128'd0);
        rst_n = 1'b1;

        // ks_done outside KEXP is ignored
        ks_done = 1'b1; tick(); ks_done = 1'b0;
        check("nokey_in_ready", 128'(in_ready), 128'd0);

        // Initial key load: one DRAIN cycle, then ks_start pulse
        key_load_valid = 1'b1; key_load_data = FIPS_KEY; tick(); key_load_valid = 1'b0;
        check("drain_klr", 128'(key_load_ready), 128'd0);
        check("drain_ks_start", 128'(ks_start), 128'd0);
        tick();
        check("ks_start_pulse", 128'(ks_start), 128'd1);
        check("key_out_loaded", key_out, FIPS_KEY);
        tick();
        check("ks_start_single", 128'(ks_start), 128'd0);
        check("kexp_in_ready", 128'(in_ready), 128'd0);
        ks_done = 1'b1; tick(); ks_done = 1'b0;
        check("run_in_ready", 128'(in_ready), 128'd1);
        check("run_klr", 128'(key_load_ready), 128'd1);
        model_key = FIPS_KEY;

        // FIPS-197 block, latency and hold under backpressure
        issue(FIPS_PT, 4'd5);
        n = 1;
        while (!out_valid && n < 40) begin tick(); n++; end
        check("fips_latency", 128'(n), 128'd11);
        check("fips_ct", out_data, FIPS_CT);
        check("fips_tag", 128'(out_tag), 128'd5);
        tick();
        check("hold_valid", 128'(out_valid), 128'd1);
        check("hold_data", out_data, FIPS_CT);
        out_ready = 1'b1;
        tick();
        check("fips_popped", 128'(out_valid), 128'd0);

        // Streaming 20 blocks in order
        n0 = n_out;
        for (int i = 0; i < 20; i++) issue({96'ha5a5a5a5_5a5a5a5a_c3c3c3c3, 32'(i)}, 4'(i));
        drain();
        check("stream_count", 128'(n_out - n0), 128'd20);

        // Backpressure: only OUT_DEPTH credits while nothing drains
        out_ready = 1'b0; n0 = n_acc; j = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_data = {96'h0, 32'(100 + j)}; in_tag = 4'(j);
            tick();
            if (accepted) j++;
        end
        check("bp_accepted", 128'(n_acc - n0), 128'd4);
        check("bp_in_ready", 128'(in_ready), 128'd0);
        out_ready = 1'b1; n0 = n_out; n = 0;
        while (j < 10 && n < 300) begin
            in_valid = 1'b1; in_data = {96'h0, 32'(100 + j)}; in_tag = 4'(j);
            tick();
            if (accepted) j++;
            n++;
        end
        in_valid = 1'b0;
        drain();
        check("bp_delivered", 128'(n_out - n0), 128'd10);

        // Key load mid-stream, simultaneous with the last input handshake
        issue(128'h11, 4'd1);
        issue(128'h22, 4'd2);
        issue(128'h33, 4'd3);
        key_load_valid = 1'b1; key_load_data = NEW_KEY;
        issue(128'h44, 4'd4);
        check("simul_key_acc", 128'(key_acc), 128'd1);
        key_load_valid = 1'b0;
        check("mid_klr", 128'(key_load_ready), 128'd0);
        n = 1;
        while (!ks_start && n < 60) begin tick(); n++; end
        check("mid_ks_start_delay", 128'(n), 128'd12);
        check("mid_old_outputs_done", 128'(exp_q.size()), 128'd0);
        check("mid_key_out", key_out, NEW_KEY);
        tick();
        check("mid_kexp_in_ready", 128'(in_ready), 128'd0);
        ks_done = 1'b1; tick(); ks_done = 1'b0;
        model_key = NEW_KEY;
        check("mid_run_in_ready", 128'(in_ready), 128'd1);
        issue(128'h0, 4'd9);
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        check("new_key_ct", out_data, NEW_KEY);
        check("new_key_tag", 128'(out_tag), 128'd9);
        drain();

`ifdef ENC_PIPE_STATS_EN
        check("stat_blocks", 128'(stat_blocks), 128'(n_acc));
`endif

        // Asynchronous reset with results buffered
        out_ready = 1'b0;
        issue(128'h55, 4'd6);
        issue(128'h66, 4'd7);
        for (int c = 0; c < 12; c++) tick();
        check("pre_rst_valid", 128'(out_valid), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'd0);
        check("arst_key_out", key_out, 128'd0);
        check("arst_in_ready", 128'(in_ready), 128'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (out_valid) n++;
        end
        check("post_rst_no_stale", 128'(n), 128'd0);
        check("post_rst_in_ready", 128'(in_ready), 128'd0);
        check("post_rst_klr", 128'(key_load_ready), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
